// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/reserve bus for the scoreboarded register file.
// The master drives addresses, write data and the reserve request; the slave
// (the register file) returns read data, busy flags and the busy count.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with a per-register busy scoreboard.
// Decode reserves a destination for a multi-cycle producer; writeback clears it.
// A reserve and a write to the same register in one cycle leave it busy, since
// the reservation belongs to a newer producer.
// Optional feature: define REGFILE_BYPASS_EN for a same-cycle write-through
// bypass on both read ports. Without it, reads show pre-edge state.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 1 << ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   mem_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [CNT_W-1:0]    busy_cnt_r;
    logic                wr_ok_s;
    logic                rsv_ok_s;
    logic [DATA_W-1:0]   rd_data1_s;
    logic [DATA_W-1:0]   rd_data2_s;
    logic                rd_busy1_s;
    logic                rd_busy2_s;

    // Address maps onto an implemented register.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS));
    endfunction

    // Address is the hardwired zero register.
    function automatic logic addr_is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 32'sd1) && (a == {ADDR_W{1'b0}});
    endfunction

    // Number of set bits in a busy vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Qualify write and reserve requests against illegal addresses and r0.
    always_comb begin
        wr_ok_s  = bus.wr_en  && addr_legal(bus.wr_addr)  && !addr_is_zero(bus.wr_addr);
        rsv_ok_s = bus.rsv_en && addr_legal(bus.rsv_addr) && !addr_is_zero(bus.rsv_addr);
    end

    // Next busy vector: a reserve beats a write-clear on the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_nxt_s[i] = (rsv_ok_s && (bus.rsv_addr == ADDR_W'(i))) ? 1'b1 :
                            (wr_ok_s  && (bus.wr_addr  == ADDR_W'(i))) ? 1'b0 :
                            busy_r[i];
        end
    end

    // Register array storage; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Busy scoreboard and its popcount advance on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {NUM_REGS{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    // Read port 1: zero for illegal/zero register, optional bypass, else array.
    always_comb begin
        rd_data1_s = {DATA_W{1'b0}};
        rd_busy1_s = 1'b0;
        if (!addr_legal(bus.rd_addr1) || addr_is_zero(bus.rd_addr1)) begin
            rd_data1_s = {DATA_W{1'b0}};
            rd_busy1_s = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_ok_s && (bus.wr_addr == bus.rd_addr1)) begin
            rd_data1_s = bus.wr_data;
            rd_busy1_s = rsv_ok_s && (bus.rsv_addr == bus.wr_addr);
        end
`endif
        else begin
            rd_data1_s = mem_r[bus.rd_addr1];
            rd_busy1_s = busy_r[bus.rd_addr1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd_data2_s = {DATA_W{1'b0}};
        rd_busy2_s = 1'b0;
        if (!addr_legal(bus.rd_addr2) || addr_is_zero(bus.rd_addr2)) begin
            rd_data2_s = {DATA_W{1'b0}};
            rd_busy2_s = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_ok_s && (bus.wr_addr == bus.rd_addr2)) begin
            rd_data2_s = bus.wr_data;
            rd_busy2_s = rsv_ok_s && (bus.rsv_addr == bus.wr_addr);
        end
`endif
        else begin
            rd_data2_s = mem_r[bus.rd_addr2];
            rd_busy2_s = busy_r[bus.rd_addr2];
        end
    end

    assign bus.rd_data1 = rd_data1_s;
    assign bus.rd_data2 = rd_data2_s;
    assign bus.rd_busy1 = rd_busy1_s;
    assign bus.rd_busy2 = rd_busy2_s;
    assign bus.busy_cnt = busy_cnt_r;

endmodule
